// File: rtl/mul_shift_add32_pkg.sv
// Shared constants and state encoding for the iterative shift-add multiplier.
package mul_shift_add32_pkg;
  localparam int unsigned W     = 32;
  localparam int unsigned PW    = 64;
  localparam int unsigned CNT_W = 6;

  // 2'd3 is unused and treated as IDLE by the next-state decode
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/mul_shift_add32_if.sv
// Operand/product valid-ready bundle for mul_shift_add32.
interface mul_shift_add32_if;
  import mul_shift_add32_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/mul_shift_add32_adder.sv
// AdderLA32bit: 32-bit adder built from 4-bit carry-lookahead groups.
module AdderLA32bit (
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  localparam int NG = 8;

  logic [31:0] g, p, ci;
  logic [NG:0] c;

  assign g    = op1 & op2;
  assign p    = op1 ^ op2;
  assign c[0] = cin;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    logic [3:0] gg, pp;
    logic       c0;
    assign gg = g[k*4 +: 4];
    assign pp = p[k*4 +: 4];
    assign c0 = c[k];

    // All group carries are flattened sums of products of the group inputs
    assign ci[k*4]     = c0;
    assign ci[k*4 + 1] = gg[0] | (pp[0] & c0);
    assign ci[k*4 + 2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c0);
    assign ci[k*4 + 3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                       | (pp[2] & pp[1] & pp[0] & c0);
    assign c[k+1]      = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                       | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & c0);
  end

  assign sum  = p ^ ci;
  assign cout = c[NG];
endmodule

// File: rtl/mul_shift_add32.sv
// Iterative unsigned 32x32->64 multiplier: one conditional add-and-shift per clock.
module mul_shift_add32
  import mul_shift_add32_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  mul_shift_add32_if.slave bus
);
  state_e           state_q, state_d;
  logic [W-1:0]     acc_hi, lo, mcand;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     addend, sum;
  logic             cout;
  logic             accept, last;

  assign addend = lo[0] ? mcand : '0;

  AdderLA32bit u_adder (
    .op1  (acc_hi),
    .op2  (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  assign last = (cnt == CNT_W'(W-1));

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state_q)
      RUN: begin
        bus.busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: begin
        bus.in_ready = 1'b1;
        state_d      = bus.in_valid ? RUN : IDLE;
      end
    endcase
  end

  assign accept      = bus.in_valid & bus.in_ready;
  assign bus.product = bus.out_valid ? {acc_hi, lo} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Carry-out becomes the new MSB of acc_hi; sum LSB shifts into lo
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi <= '0;
      lo     <= '0;
      mcand  <= '0;
      cnt    <= '0;
    end else if (accept) begin
      acc_hi <= '0;
      lo     <= bus.b;
      mcand  <= bus.a;
      cnt    <= '0;
    end else if (state_q == RUN) begin
      acc_hi <= {cout, sum[W-1:1]};
      lo     <= {sum[0], lo[W-1:1]};
      cnt    <= cnt + 1'b1;
    end
  end
endmodule
